// File: rtl/host_config_sequencer_pkg.sv
// Shared widths and sequencer state encoding for the host configuration path.
package host_config_sequencer_pkg;

  localparam int unsigned H_C_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/host_config_sequencer_if.sv
// Host-side valid/ready push channel feeding the configuration word queue.
interface host_config_sequencer_if #(
  parameter int unsigned CFG_W = host_config_sequencer_pkg::H_C_W
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CFG_W-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/host_cfg_fifo.sv
// Register-array synchronous FIFO with combinational head; pointers wrap on the
// power-of-two depth.
module host_cfg_fifo #(
  parameter  int unsigned W     = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/host_config_sequencer.sv
// Queues host configuration words and issues them one at a time, holding each
// on host_config until SPM and every LSU have reported completion.
module host_config_sequencer
  import host_config_sequencer_pkg::*;
#(
  parameter  int unsigned CFG_W   = H_C_W,
  parameter  int unsigned DEPTH   = 4,
  parameter  int unsigned NUM_LSU = 4,
  localparam int unsigned QW      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  host_config_sequencer_if.slave  cfg,
  input  logic                    start,
  output logic [CFG_W-1:0]        host_config,
  output logic                    cfg_issue,
  input  logic [NUM_LSU-1:0]      lsu_done,
  input  logic                    spm_done,
  output logic                    busy,
  output logic                    seq_done,
  output logic [QW-1:0]           q_count
);

  seq_state_t       state;
  logic [NUM_LSU:0] done_mask;
  logic [NUM_LSU:0] done_now;
  logic [CFG_W-1:0] head;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  assign push          = cfg.cfg_valid && !full;
  assign pop           = (state == ST_ISSUE);
  assign cfg.cfg_ready = !full;
  assign busy          = (state != ST_IDLE);
  assign done_now      = done_mask | {spm_done, lsu_done};

  host_cfg_fifo #(
    .W     (CFG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (cfg.cfg_data),
    .head  (head),
    .count (q_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      host_config <= '0;
      cfg_issue   <= 1'b0;
      seq_done    <= 1'b0;
      done_mask   <= '0;
    end else begin
      cfg_issue <= 1'b0;
      seq_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !empty) begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          host_config <= head;
          cfg_issue   <= 1'b1;
          done_mask   <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          done_mask <= done_now;
          if (&done_now) begin
            // a word pushed on this same edge still keeps the sequence running
            if (!empty || push) begin
              state <= ST_ISSUE;
            end else begin
              state    <= ST_IDLE;
              seq_done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
